// File: rtl/router_rd_arbiter.sv
// Read-side scheduler of the 1x3 router: grants whole packets round-robin and drains
// the granted FIFO through a 2-entry skid buffer onto one valid/ready byte channel.
module router_rd_arbiter #(
  parameter int TIMEOUT = 32
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_port,
  output logic       pkt_abort,
  output logic       arb_busy
);
  localparam int         NUM_PORTS = 3;
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HDR, HWAIT, BODY} state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } beat_t;

  logic [NUM_PORTS-1:0]      vld;
  logic [NUM_PORTS-1:0][7:0] fdata;
  logic [NUM_PORTS-1:0]      rd_en;

  assign vld   = {vld_out_2, vld_out_1, vld_out_0};
  assign fdata = {data_out_2, data_out_1, data_out_0};

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_q, gnt_d;
  logic [6:0] rem_q, rem_d;
  logic [7:0] tmo_q, tmo_d;

  beat_t [1:0] buf_q, buf_d;
  logic [1:0]  cnt_q, cnt_d, cnt_mid;
  logic        infl_q, infl_sop_q, infl_eop_q;
  logic [1:0]  infl_port_q;
  beat_t       push_beat;

  logic       pop, room, rd_go, abort, starve, found, vld_g;
  logic [1:0] idx;
  logic [2:0] occ;

  assign pop   = (cnt_q != 2'd0) && out_ready;
  assign occ   = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
  assign room  = occ < 3'd2;
  assign vld_g = vld[gnt_q];

  // FSM: grant, header fetch, header capture, body drain
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    rd_go   = 1'b0;
    abort   = 1'b0;
    starve  = 1'b0;
    found   = 1'b0;
    idx     = 2'd0;
    case (state_q)
      IDLE: begin
        for (int k = 1; k <= NUM_PORTS; k++) begin
          idx = 2'((int'(ptr_q) + k) % NUM_PORTS);
          if (!found && vld[idx]) begin
            found   = 1'b1;
            gnt_d   = idx;
            state_d = HDR;
            tmo_d   = 8'd0;
          end
        end
      end
      HDR: begin
        if (vld_g && room) begin
          rd_go   = 1'b1;
          tmo_d   = 8'd0;
          state_d = HWAIT;
        end else if (!vld_g) begin
          starve = 1'b1;
        end
      end
      HWAIT: begin
        rem_d   = 7'(fdata[infl_port_q][7:2]) + 7'd1;
        state_d = BODY;
      end
      BODY: begin
        if (vld_g && room) begin
          rd_go = 1'b1;
          tmo_d = 8'd0;
          rem_d = rem_q - 7'd1;
          if (rem_q == 7'd1) begin
            ptr_d   = gnt_q;
            state_d = IDLE;
          end
        end else if (!vld_g) begin
          starve = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Only an empty granted FIFO counts toward the abort; buffer back-pressure does not
    if (starve) begin
      if (tmo_q == TMO_LAST) begin
        abort   = 1'b1;
        ptr_d   = gnt_q;
        tmo_d   = 8'd0;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    assign rd_en[p] = rd_go && resetn && (gnt_q == 2'(p));
  end

  assign read_enb_0 = rd_en[0];
  assign read_enb_1 = rd_en[1];
  assign read_enb_2 = rd_en[2];

  always_comb begin
    push_beat.data = fdata[infl_port_q];
    push_beat.sop  = infl_sop_q;
    push_beat.eop  = infl_eop_q;
    push_beat.port = infl_port_q;
  end

  // Skid buffer: pop shifts the tail to the head, then the arriving byte fills the next slot
  always_comb begin
    buf_d   = buf_q;
    cnt_mid = cnt_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      cnt_mid  = cnt_q - 2'd1;
    end
    cnt_d = cnt_mid;
    if (infl_q) begin
      buf_d[cnt_mid[0]] = push_beat;
      cnt_d             = cnt_mid + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd2;
      gnt_q       <= 2'd0;
      rem_q       <= 7'd0;
      tmo_q       <= 8'd0;
      buf_q       <= '0;
      cnt_q       <= 2'd0;
      infl_q      <= 1'b0;
      infl_sop_q  <= 1'b0;
      infl_eop_q  <= 1'b0;
      infl_port_q <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      infl_q  <= rd_go;
      if (rd_go) begin
        infl_sop_q  <= (state_q == HDR);
        infl_eop_q  <= (state_q == BODY) && (rem_q == 7'd1);
        infl_port_q <= gnt_q;
      end
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf_q[0].data;
  assign out_sop   = buf_q[0].sop;
  assign out_eop   = buf_q[0].eop;
  assign out_port  = buf_q[0].port;
  assign pkt_abort = abort;
  assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_router_rd_arbiter.sv
// Bench for router_rd_arbiter: queue-backed FIFO models upstream, scoreboard on the output channel.
`timescale 1ns/1ps
module tb_router_rd_arbiter;
  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } beat_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
  logic [7:0] data_out_0 = 8'h00, data_out_1 = 8'h00, data_out_2 = 8'h00;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       out_ready = 1'b0;
  logic       out_valid, out_sop, out_eop, pkt_abort, arb_busy;
  logic [7:0] out_data;
  logic [1:0] out_port;

  int n_cmp = 0;
  int n_err = 0;
  int rdn0 = 0, rdn1 = 0, rdn2 = 0, beats = 0, outst = 0;

  logic [7:0] fq0[$], fq1[$], fq2[$];
  beat_t      exp_q[$];
  logic       prev_stall = 1'b0;
  beat_t      prev_beat = '0;

  router_rd_arbiter #(.TIMEOUT(32)) dut (
    .clock(clock), .resetn(resetn),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port),
    .pkt_abort(pkt_abort), .arb_busy(arb_busy)
  );

  always #5 clock = ~clock;

  // Upstream FIFOs: read data appears the cycle after the strobe
  always @(posedge clock) begin
    if (read_enb_0 && fq0.size() != 0) data_out_0 <= fq0.pop_front();
    if (read_enb_1 && fq1.size() != 0) data_out_1 <= fq1.pop_front();
    if (read_enb_2 && fq2.size() != 0) data_out_2 <= fq2.pop_front();
    vld_out_0 <= (fq0.size() != 0);
    vld_out_1 <= (fq1.size() != 0);
    vld_out_2 <= (fq2.size() != 0);
  end

  // Scoreboard and channel-rule monitor
  always @(negedge clock) begin
    int    rd_any;
    beat_t got, e;
    rd_any = int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2);
    got    = {out_data, out_sop, out_eop, out_port};
    if (!resetn) begin
      outst      = 0;
      prev_stall = 1'b0;
    end else begin
      rdn0 += int'(read_enb_0);
      rdn1 += int'(read_enb_1);
      rdn2 += int'(read_enb_2);
      outst += rd_any;
      if (prev_stall) begin
        n_cmp++;
        if (!out_valid || got !== prev_beat) begin
          n_err++;
          $display("FAIL stall_hold: valid=%0b beat=%h required valid=1 beat=%h", out_valid, got, prev_beat);
        end
      end
      if (out_valid && out_ready) begin
        outst--;
        beats++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra: got beat %h with nothing expected", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL sb_beat: got %h (data,sop,eop,port) required %h", got, e);
          end
        end
      end
      if (rd_any != 0) begin
        n_cmp++;
        if (rd_any > 1 || outst > 2) begin
          n_err++;
          $display("FAIL read_rule: reads=%0d outstanding=%0d required reads<=1 outstanding<=2", rd_any, outst);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = got;
    end
  end

  task automatic push_byte(input int p, input logic [7:0] b);
    case (p)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endtask

  task automatic load_pkt(input int p, input int len, input logic [7:0] seed);
    logic [7:0] hdr, par, b;
    hdr = {6'(len), 2'(p)};
    par = hdr;
    push_byte(p, hdr);
    exp_q.push_back({hdr, 1'b1, 1'b0, 2'(p)});
    for (int i = 0; i < len; i++) begin
      b = seed + 8'(i);
      par ^= b;
      push_byte(p, b);
      exp_q.push_back({b, 1'b0, 1'b0, 2'(p)});
    end
    push_byte(p, par);
    exp_q.push_back({par, 1'b0, 1'b1, 2'(p)});
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    resetn = 1'b0;
    out_ready = 1'b0;
    fq0.delete(); fq1.delete(); fq2.delete(); exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    do_reset();
    @(negedge clock); #1;
    obs = {out_valid, out_data, out_sop, out_eop, out_port, pkt_abort, arb_busy,
           read_enb_0, read_enb_1, read_enb_2};
    n_cmp++;
    if (obs !== 18'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", obs);
    end
  endtask

  task automatic test_single();
    int b1, bo, bb;
    do_reset();
    b1 = rdn1; bo = rdn0 + rdn2; bb = beats;
    load_pkt(1, 3, 8'h40);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clock);
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL single_drain: %0d beats left required 0", exp_q.size()); end
    n_cmp++;
    if (rdn1 - b1 != 5) begin n_err++; $display("FAIL single_reads: got %0d required 5", rdn1 - b1); end
    n_cmp++;
    if (beats - bb != 5) begin n_err++; $display("FAIL single_beats: got %0d required 5", beats - bb); end
    n_cmp++;
    if (rdn0 + rdn2 - bo != 0) begin n_err++; $display("FAIL single_other_reads: got %0d required 0", rdn0 + rdn2 - bo); end
  endtask

  task automatic test_round_robin();
    int base, b0, idle;
    bit started;
    do_reset();
    base = rdn0 + rdn1 + rdn2; b0 = rdn0; idle = 0; started = 1'b0;
    load_pkt(0, 2, 8'h10);
    load_pkt(1, 2, 8'h20);
    load_pkt(2, 2, 8'h30);
    load_pkt(0, 2, 8'h50);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      @(negedge clock); #1;
      if (arb_busy) started = 1'b1;
      else if (started && (rdn0 + rdn1 + rdn2 - base) < 16) idle++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_drain: %0d beats left required 0", exp_q.size()); end
    n_cmp++;
    if (idle != 3) begin n_err++; $display("FAIL rr_idle_gaps: got %0d required 3", idle); end
    n_cmp++;
    if (rdn0 - b0 != 8) begin n_err++; $display("FAIL rr_port0_reads: got %0d required 8", rdn0 - b0); end
  endtask

  task automatic test_backpressure();
    int b2;
    do_reset();
    b2 = rdn2;
    load_pkt(2, 4, 8'h60);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      @(posedge clock); #1;
      out_ready = (c % 3 == 0);
    end
    out_ready = 1'b1;
    @(negedge clock); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: %0d beats left required 0", exp_q.size()); end
    n_cmp++;
    if (rdn2 - b2 != 6) begin n_err++; $display("FAIL bp_reads: got %0d required 6", rdn2 - b2); end
  endtask

  task automatic test_back_to_back();
    int b0, first;
    bit seen;
    do_reset();
    b0 = rdn0; first = -1; seen = 1'b0;
    load_pkt(0, 2, 8'h70);
    load_pkt(0, 1, 8'h80);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(negedge clock); #1;
      if (arb_busy) seen = 1'b1;
      else if (seen && first < 0) first = rdn0 - b0;
    end
    n_cmp++;
    if (first != 4) begin n_err++; $display("FAIL b2b_first_grant_reads: got %0d required 4", first); end
    n_cmp++;
    if (rdn0 - b0 != 7) begin n_err++; $display("FAIL b2b_total_reads: got %0d required 7", rdn0 - b0); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain: %0d beats left required 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int  b0, starve;
    bit  got_abort;
    do_reset();
    b0 = rdn0; starve = 0; got_abort = 1'b0;
    push_byte(0, 8'h0C);
    exp_q.push_back({8'h0C, 1'b1, 1'b0, 2'd0});
    push_byte(0, 8'hA5);
    exp_q.push_back({8'hA5, 1'b0, 1'b0, 2'd0});
    load_pkt(1, 1, 8'h90);
    for (int c = 0; c < 200 && !got_abort; c++) begin
      @(negedge clock); #1;
      if (arb_busy && !vld_out_0 && (rdn0 - b0 == 2)) starve++;
      if (pkt_abort) got_abort = 1'b1;
    end
    n_cmp++;
    if (!got_abort || starve != 32) begin
      n_err++;
      $display("FAIL tmo_abort_cycle: abort=%0b starved=%0d required abort=1 starved=32", got_abort, starve);
    end
    @(negedge clock); #1;
    n_cmp++;
    if ({pkt_abort, arb_busy} !== 2'b00) begin
      n_err++;
      $display("FAIL tmo_after_abort: abort,busy=%b required 00", {pkt_abort, arb_busy});
    end
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clock);
    @(negedge clock); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL tmo_drain: %0d beats left required 0", exp_q.size()); end
    n_cmp++;
    if (rdn0 - b0 != 2) begin n_err++; $display("FAIL tmo_port0_reads: got %0d required 2", rdn0 - b0); end
  endtask

  task automatic test_reset_mid();
    int          b1, first;
    logic [17:0] obs;
    do_reset();
    load_pkt(1, 1, 8'hB0);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clock);
    b1 = rdn1;
    load_pkt(1, 5, 8'hC0);
    for (int c = 0; c < 100 && (rdn1 - b1) < 4; c++) begin
      @(negedge clock); #1;
    end
    n_cmp++;
    if (!arb_busy) begin n_err++; $display("FAIL mid_busy_before_reset: got 0 required 1"); end
    @(posedge clock); #1;
    out_ready = 1'b0;
    resetn = 1'b0;
    @(posedge clock); #1;
    obs = {out_valid, out_data, out_sop, out_eop, out_port, pkt_abort, arb_busy,
           read_enb_0, read_enb_1, read_enb_2};
    n_cmp++;
    if (obs !== 18'd0) begin n_err++; $display("FAIL mid_reset_outputs: got %h required 0", obs); end
    fq0.delete(); fq1.delete(); fq2.delete(); exp_q.delete();
    @(posedge clock); #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    load_pkt(0, 1, 8'hD0);
    load_pkt(1, 1, 8'hD8);
    load_pkt(2, 1, 8'hE0);
    first = -1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(negedge clock); #1;
      if (first < 0) begin
        if (read_enb_0) first = 0;
        else if (read_enb_1) first = 1;
        else if (read_enb_2) first = 2;
      end
    end
    n_cmp++;
    if (first != 0) begin n_err++; $display("FAIL mid_first_grant: got port %0d required 0", first); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_drain: %0d beats left required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
